// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - fetch PC owner, imem read issue and DEPTH-entry instruction FIFO.
// Define IFQ_FLUSH_STATS_EN to add the flush_count/flushed_words statistics outputs.
module instr_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int PC_STEP = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [31:0]   startPC,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr,
  output logic [31:0]   instr_pc,
  output logic [AW:0]   q_count
`ifdef IFQ_FLUSH_STATS_EN
  ,
  output logic [15:0]   flush_count,
  output logic [15:0]   flushed_words
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_FULL, S_FLUSH} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   inflight_pc_q;
  logic          inflight_q;
  logic          started_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic          credit, req, push, pop;

  // Credit counts the read already in flight so a full FIFO can never be pushed.
  assign credit = ({1'b0, count_q} + (AW+2)'(inflight_q)) < (AW+2)'(DEPTH);
  assign push   = inflight_q && !redirect && (state_q != S_FLUSH);
  assign pop    = instr_valid && instr_ready;

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? data_mem[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q] : '0;
  assign q_count     = count_q;
  assign imem_req    = req;
  assign imem_addr   = req ? fetch_pc_q : '0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req        = 1'b0;
    if (redirect) begin
      state_d    = S_FLUSH;
      fetch_pc_d = redirect_pc;
    end else begin
      case (state_q)
        S_FETCH: begin
          // started_q holds off the first request until the cycle after reset release.
          if (started_q) begin
            if (credit) begin
              req        = 1'b1;
              fetch_pc_d = fetch_pc_q + 32'(PC_STEP);
            end else begin
              state_d = S_FULL;
            end
          end
        end
        S_FULL:  if (credit) state_d = S_FETCH;
        S_FLUSH: state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_FETCH;
      fetch_pc_q    <= startPC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      started_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= req;
      inflight_pc_q <= fetch_pc_q;
      started_q     <= 1'b1;
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= inflight_pc_q;
    end
  end

`ifdef IFQ_FLUSH_STATS_EN
  logic [16:0] fw_sum;
  assign fw_sum = {1'b0, flushed_words} + 17'(count_q) + 17'(inflight_q);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      flush_count   <= '0;
      flushed_words <= '0;
    end else if (redirect) begin
      if (flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
      flushed_words <= fw_sum[16] ? 16'hFFFF : fw_sum[15:0];
    end
  end
`endif

endmodule
